iterative_divider: RTL and testbench



---
 rtl/iterative_divider_pkg.sv | 33 +++
 rtl/iterative_divider_div_step.sv | 27 ++
 rtl/iterative_divider.sv | 144 ++++++++++++++
 tb/tb_iterative_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and RV32M funct3 decode.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } div_state_e;

    localparam logic [2:0] Funct3Div  = 3'b100;
    localparam logic [2:0] Funct3Divu = 3'b101;
    localparam logic [2:0] Funct3Rem  = 3'b110;
    localparam logic [2:0] Funct3Remu = 3'b111;

    typedef struct packed {
        logic is_signed;
        logic op_rem;
    } div_ctrl_t;

    function automatic div_ctrl_t decode_funct3(input logic [2:0] funct3);
        div_ctrl_t ctrl;
        ctrl = '0;
        case (funct3)
            Funct3Div:  ctrl = '{is_signed: 1'b1, op_rem: 1'b0};
            Funct3Divu: ctrl = '{is_signed: 1'b0, op_rem: 1'b0};
            Funct3Rem:  ctrl = '{is_signed: 1'b1, op_rem: 1'b1};
            Funct3Remu: ctrl = '{is_signed: 1'b0, op_rem: 1'b1};
            default:    ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module iterative_divider_div_step
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_msbs;

    assign shifted = {rem_in, dvd_bit};
    // Extra top bit holds the borrow so the full WIDTH+1 partial remainder is compared.
    assign diff    = {1'b0, shifted} - {2'b00, dvs_mag};
    assign quo_bit = ~diff[WIDTH+1];
    // A kept difference is always below the divisor, so it fits in WIDTH bits.
    assign rem_out = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_msbs = diff[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider implementing RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, orig_q, orig_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d, ovf_q, ovf_d, op_rem_q, op_rem_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    iterative_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .dvd_bit (quo_q[WIDTH-1]),
        .dvs_mag (dvs_q),
        .rem_out (step_rem),
        .quo_bit (step_bit)
    );

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];

    always_comb begin
        quo_fix = q_neg_q ? -quo_q : quo_q;
        rem_fix = r_neg_q ? -rem_q : rem_q;
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = orig_q;
        end else if (ovf_q) begin
            quo_fix = MinNeg;
            rem_fix = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        orig_d     = orig_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        op_rem_d   = op_rem_q;
        result_d   = result_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d      = '0;
                    quo_d      = dvd_neg ? -dividend : dividend;
                    dvs_d      = dvs_neg ? -divisor : divisor;
                    orig_d     = dividend;
                    q_neg_d    = dvd_neg ^ dvs_neg;
                    r_neg_d    = dvd_neg;
                    div_zero_d = (divisor == '0);
                    ovf_d      = is_signed && (dividend == MinNeg) && (divisor == '1);
                    op_rem_d   = op_rem;
                    cnt_d      = CntInit;
                    state_d    = StRun;
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = op_rem_q ? rem_fix : quo_fix;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            orig_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            op_rem_q   <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            orig_q     <= orig_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            op_rem_q   <= op_rem_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed RV32M vectors, protocol and reset-abort cases.
module tb_iterative_divider;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 33;  // acceptance edge to the edge that raises done

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic             op_rem = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy, done;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    iterative_divider #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .op_rem    (op_rem),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation in value and timing.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, WIDTH'(cyc), WIDTH'(e.cyc));
                check({e.name, "_busy_at_done"}, WIDTH'(busy), '0);
            end
        end
    end

    // Drive one request; returns at the negedge after the acceptance edge.
    task automatic issue(input logic s, input logic r, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                         input string name);
        exp_t e;
        @(negedge clk);
        start = 1'b1; is_signed = s; op_rem = r; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        e.res = exp; e.cyc = cyc + LAT; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", WIDTH'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int a;
        exp_t e;
        repeat (3) @(negedge clk);
        check("reset_busy", WIDTH'(busy), '0);
        check("reset_done", WIDTH'(done), '0);
        check("reset_result", result, '0);
        reset = 1'b0;

        issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, "divu_100_7");
        drain();
        issue(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, "remu_100_7");
        drain();
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        drain();
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        drain();
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
        drain();
        issue(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");
        drain();
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1");
        drain();
        issue(1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        drain();
        issue(1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, "remu_by0");
        drain();
        issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_m5_by0");
        drain();
        issue(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_m5_by0");
        drain();

        // Overflow: also count busy cycles, which must match a normal op.
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            if (busy) nb++;
            @(negedge clk);
        end
        check("ovf_busy_cycles", WIDTH'(nb), WIDTH'(LAT));
        drain();
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
        drain();

        // start held for 40 cycles: second op accepted on the done cycle.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_rem = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        a = cyc;
        e.res = 32'd14; e.cyc = a + LAT;         e.name = "held_op1"; sb.push_back(e);
        e.res = 32'd14; e.cyc = a + 2 * LAT + 1; e.name = "held_op2"; sb.push_back(e);
        repeat (39) @(negedge clk);
        start = 1'b0;
        drain();

        // start while busy with different operands must be ignored.
        issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, "busy_ignore");
        repeat (5) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; op_rem = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-operation aborts without a done pulse.
        issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, "aborted");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", WIDTH'(busy), '0);
        check("abort_done", WIDTH'(done), '0);
        check("abort_result", result, '0);
        sb.delete();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, "divu_9_3_after_abort");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
